keypad_lock_ctrl: RTL and testbench
===================================

Name: keypad_lock_ctrl

Overview:
Parametrised keypad code-lock controller.
- Takes the 16-bit one-hot keypad code from the keypad scanner.
- Builds a DIGITS-long entry and shows it as nibbles for the 7-segment display driver.
- Checks the entry against PASSWORD on ENTER and counts failed tries.
- Enforces a timed or admin-cleared lockout and drives a buzzer with distinct key, OK and fail beeps.
- Unlike the previous-generation block, it accepts repeated identical digits by detecting press edges, not value changes.

Parameters:
DIGITS, 3, code length in digits (1..8)
PASSWORD, 12'h246, expected code, 4*DIGITS bits, first-entered digit in the MS nibble
MAX_TRIES, 6, failed ENTERs that trigger lockout (>=1)
LOCKOUT_CYC, 0, lockout duration in clk cycles; 0 = exit only by CLEAR_ALL
TONE_HALF, 50000, buzzer half-period in cycles
KEY_BEEP_CYC, 10000000, key-click beep length
OK_BEEP_CYC, 30000000, success beep length
FAIL_BEEP_CYC, 100000000, failure beep length

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
onehot  in  16  keypad code; debounced and synchronous to clk upstream; 0 = no key
disp  out  4*DIGITS  display nibbles; nibble 0 = most recent digit; 4'hF = blank
tries  out  $clog2(MAX_TRIES+1)  failed attempts
unlocked  out  1  high in OPEN
locked_out  out  1  high in LOCKOUT
key_evt  out  1  one-cycle pulse per accepted key
buzzer  out  1  square-wave buzzer drive

Behaviour:
- Reset, sampled on the clk edge, gives: state ENTRY, disp all-F, cnt 0, tries 0, unlocked 0, locked_out 0, key_evt 0, buzzer 0, beep idle. This applies mid-beep and mid-lockout.
- Key decode:
  - Digits: bit3=0, bit7=1, bit6=2, bit5=3, bit11=4, bit10=5, bit9=6, bit15=7, bit14=8, bit13=9.
  - Controls: bit0=ENTER, bit12=CLEAR_ENTRY, bit8=CLEAR_ALL.
  - Bits 1, 2 and 4, and any multi-bit value, are no-key.
- Press event: previous-cycle onehot == 0 and current onehot is a valid single key.
  - The event is acted on at that edge; outputs are visible after it.
  - A held key produces one event. Pressing the same key again requires release to 0.
- key_evt pulses only for events that change state or disp.
- ENTRY state:
  - Digit with cnt<DIGITS: disp shifts left one nibble, new digit goes into nibble 0, cnt+1, KEY beep.
  - Digit with cnt==DIGITS: ignored.
  - ENTER with cnt<DIGITS: ignored, no try consumed.
  - ENTER with cnt==DIGITS and disp==PASSWORD: go to OPEN, tries=0, disp all-C, OK beep.
  - ENTER with cnt==DIGITS and a mismatch: tries+1, disp all-F, cnt=0, FAIL beep. If the new tries==MAX_TRIES, go to LOCKOUT.
  - CLEAR_ENTRY: disp all-F, cnt=0, tries unchanged, KEY beep.
- OPEN state: unlocked=1. CLEAR_ENTRY relocks (ENTRY, disp all-F, cnt 0). Digits and ENTER are ignored.
- LOCKOUT state:
  - locked_out=1 and disp all-0. All keys except CLEAR_ALL are ignored and silent.
  - With LOCKOUT_CYC>0, a counter starts at 0 on entry. At count LOCKOUT_CYC-1 the state returns to ENTRY with tries=0 and disp all-F.
- CLEAR_ALL in any state: ENTRY, tries=0, cnt=0, disp all-F, lockout counter cleared, KEY beep.
- Beep generator:
  - A start with a length reloads the duration counter and the tone counter and forces buzzer=1.
  - buzzer toggles each TONE_HALF cycles.
  - When the duration expires, buzzer=0 and the generator goes idle.
  - A new start always restarts, even mid-beep.
- Simultaneous beep requests cannot occur because there is one event per cycle. Beep priority when encoded is FAIL > OK > KEY.
- Counter widths use $clog2 of the parameter. There is no wrap: tries saturates at MAX_TRIES.

Decomposition:
- Package keypad_lock_pkg holds:
  - the state enum (ENTRY, OPEN, LOCKOUT);
  - the beep-kind enum (KEY, OK, FAIL);
  - key-bit constants;
  - the nibble constants BLANK=4'hF, OPEN_NIB=4'hC, LOCK_NIB=4'h0.
- Sub-module beep_gen (params TONE_HALF and the three lengths; ports clk, rst, start, kind, buzzer).

Test Plan:
- Reset, then press 2,4,6 with a release between each, then ENTER -> disp 0x246 before ENTER; after ENTER unlocked=1, disp 0xCCC, tries 0, buzzer active for OK_BEEP_CYC (scaled-down params).
- Press 1,1,1 then ENTER with PASSWORD=0x111 -> three separate digit events, unlocked=1. Holding 1 for 100 cycles -> single digit event.
- Enter wrong code 1,2,3 + ENTER six times with MAX_TRIES=6, LOCKOUT_CYC=0 -> tries 1..6, FAIL beep each time, locked_out=1, disp 0x000. Digits are then ignored and CLEAR_ALL -> ENTRY, tries 0.
- LOCKOUT_CYC=20 after lockout -> locked_out drops exactly 20 cycles after entry, tries=0, disp 0xFFF.
- Press 2,4 then ENTER -> no change, tries 0. Press a 4th digit after 3 -> ignored. CLEAR_ENTRY -> disp 0xFFF, cnt 0.
- Assert rst mid-FAIL-beep and mid-entry -> next cycle buzzer 0, disp 0xFFF, tries 0. Onehot=0x0003 or 0x0002 -> no event, no key_evt.

Source files
------------

// File: rtl/keypad_lock_pkg.sv
// Shared types and constants for the keypad code-lock controller:
// FSM states, beep kinds, keypad one-hot key masks, display nibbles,
// and the key decoder.
package keypad_lock_pkg;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    BEEP_KEY  = 2'd0,
    BEEP_OK   = 2'd1,
    BEEP_FAIL = 2'd2
  } beep_kind_e;

  // Keypad scanner one-hot masks
  localparam logic [15:0] KEY_ENTER     = 16'h0001;
  localparam logic [15:0] KEY_D0        = 16'h0008;
  localparam logic [15:0] KEY_D3        = 16'h0020;
  localparam logic [15:0] KEY_D2        = 16'h0040;
  localparam logic [15:0] KEY_D1        = 16'h0080;
  localparam logic [15:0] KEY_CLR_ALL   = 16'h0100;
  localparam logic [15:0] KEY_D6        = 16'h0200;
  localparam logic [15:0] KEY_D5        = 16'h0400;
  localparam logic [15:0] KEY_D4        = 16'h0800;
  localparam logic [15:0] KEY_CLR_ENTRY = 16'h1000;
  localparam logic [15:0] KEY_D9        = 16'h2000;
  localparam logic [15:0] KEY_D8        = 16'h4000;
  localparam logic [15:0] KEY_D7        = 16'h8000;

  // Display nibbles
  localparam logic [3:0] BLANK    = 4'hF;
  localparam logic [3:0] OPEN_NIB = 4'hC;
  localparam logic [3:0] LOCK_NIB = 4'h0;

  typedef struct packed {
    logic       valid;
    logic       is_digit;
    logic [3:0] digit;
    logic       enter;
    logic       clr_entry;
    logic       clr_all;
  } key_t;

  // Map a raw keypad code to a key; unused bits and multi-bit codes are no-key
  function automatic key_t decode_key(input logic [15:0] oh);
    key_t k;
    k          = '0;
    k.valid    = 1'b1;
    k.is_digit = 1'b1;
    case (oh)
      KEY_D0:        k.digit = 4'd0;
      KEY_D1:        k.digit = 4'd1;
      KEY_D2:        k.digit = 4'd2;
      KEY_D3:        k.digit = 4'd3;
      KEY_D4:        k.digit = 4'd4;
      KEY_D5:        k.digit = 4'd5;
      KEY_D6:        k.digit = 4'd6;
      KEY_D7:        k.digit = 4'd7;
      KEY_D8:        k.digit = 4'd8;
      KEY_D9:        k.digit = 4'd9;
      KEY_ENTER: begin
        k.is_digit = 1'b0;
        k.enter    = 1'b1;
      end
      KEY_CLR_ENTRY: begin
        k.is_digit  = 1'b0;
        k.clr_entry = 1'b1;
      end
      KEY_CLR_ALL: begin
        k.is_digit = 1'b0;
        k.clr_all  = 1'b1;
      end
      default: begin
        k.valid    = 1'b0;
        k.is_digit = 1'b0;
      end
    endcase
    return k;
  endfunction

endpackage

// File: rtl/beep_gen.sv
// Buzzer tone generator: a start pulse picks a beep length by kind,
// restarts the tone from a high half-period and plays a square wave
// until the length runs out.
module beep_gen
  import keypad_lock_pkg::*;
#(
  parameter int TONE_HALF     = 50000,
  parameter int KEY_BEEP_CYC  = 10000000,
  parameter int OK_BEEP_CYC   = 30000000,
  parameter int FAIL_BEEP_CYC = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] kind,
  output logic       buzzer
);

  localparam int MAX_KO  = (KEY_BEEP_CYC > OK_BEEP_CYC) ? KEY_BEEP_CYC : OK_BEEP_CYC;
  localparam int MAX_LEN = (MAX_KO > FAIL_BEEP_CYC) ? MAX_KO : FAIL_BEEP_CYC;
  localparam int DUR_W   = $clog2(MAX_LEN + 1);
  localparam int TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

  logic [DUR_W-1:0]  dur_q;
  logic [TONE_W-1:0] tone_q;
  logic              active_q;
  logic              buzzer_q;
  logic [DUR_W-1:0]  len_m1_d;

  // Duration reload value for the requested kind; FAIL outranks OK outranks KEY
  always_comb begin
    len_m1_d = DUR_W'(KEY_BEEP_CYC - 1);
    case (kind)
      BEEP_FAIL: len_m1_d = DUR_W'(FAIL_BEEP_CYC - 1);
      BEEP_OK:   len_m1_d = DUR_W'(OK_BEEP_CYC - 1);
      default:   len_m1_d = DUR_W'(KEY_BEEP_CYC - 1);
    endcase
  end

  // Duration and half-period counters; a start always restarts the beep
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      buzzer_q <= 1'b0;
      dur_q    <= '0;
      tone_q   <= '0;
    end else if (start) begin
      active_q <= 1'b1;
      buzzer_q <= 1'b1;
      dur_q    <= len_m1_d;
      tone_q   <= '0;
    end else if (active_q) begin
      if (dur_q == '0) begin
        active_q <= 1'b0;
        buzzer_q <= 1'b0;
      end else begin
        dur_q <= dur_q - DUR_W'(1);
        if (tone_q == TONE_W'(TONE_HALF - 1)) begin
          tone_q   <= '0;
          buzzer_q <= ~buzzer_q;
        end else begin
          tone_q <= tone_q + TONE_W'(1);
        end
      end
    end
  end

  assign buzzer = buzzer_q;

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad code-lock controller. Detects key presses as edges out of the
// idle (all-zero) keypad code, builds a DIGITS-long entry shown as
// display nibbles, checks it against PASSWORD on ENTER, counts failed
// tries into a timed or CLEAR_ALL-released lockout, and drives a buzzer.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int                  DIGITS        = 3,
  parameter logic [4*DIGITS-1:0] PASSWORD      = 12'h246,
  parameter int                  MAX_TRIES     = 6,
  parameter int                  LOCKOUT_CYC   = 0,
  parameter int                  TONE_HALF     = 50000,
  parameter int                  KEY_BEEP_CYC  = 10000000,
  parameter int                  OK_BEEP_CYC   = 30000000,
  parameter int                  FAIL_BEEP_CYC = 100000000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    onehot,
  output logic [4*DIGITS-1:0]            disp,
  output logic [$clog2(MAX_TRIES+1)-1:0] tries,
  output logic                           unlocked,
  output logic                           locked_out,
  output logic                           key_evt,
  output logic                           buzzer
);

  localparam int TRIES_W   = $clog2(MAX_TRIES + 1);
  localparam int CNT_W     = $clog2(DIGITS + 1);
  localparam int LOCK_W    = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
  localparam int LOCK_LAST = (LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0;

  localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{BLANK}};
  localparam logic [4*DIGITS-1:0] ALL_OPEN  = {DIGITS{OPEN_NIB}};
  localparam logic [4*DIGITS-1:0] ALL_LOCK  = {DIGITS{LOCK_NIB}};

  lock_state_e          state_q;
  logic [4*DIGITS-1:0]  disp_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TRIES_W-1:0]   tries_q;
  logic [LOCK_W-1:0]    lock_cnt_q;
  logic                 unlocked_q;
  logic                 locked_out_q;
  logic                 key_evt_q;
  logic [15:0]          onehot_q;

  key_t                 key_dec;
  logic                 press;
  logic                 act_digit;
  logic                 act_ok;
  logic                 act_fail;
  logic                 act_clr_entry;
  logic                 act_relock;
  logic                 act_clr_all;
  logic                 lock_done;
  logic                 beep_start;
  beep_kind_e           beep_kind;
  logic                 key_accept;
  logic [4*DIGITS-1:0]  disp_shift_d;
  logic [TRIES_W-1:0]   tries_inc_d;

  // Classify this cycle's press into the single action it triggers, plus
  // the beep request; a press that triggers nothing is silent and gives no key_evt
  always_comb begin
    key_dec       = decode_key(onehot);
    press         = key_dec.valid && (onehot_q == '0);
    act_digit     = press && key_dec.is_digit && (state_q == ENTRY) &&
                    (cnt_q < CNT_W'(DIGITS));
    act_ok        = press && key_dec.enter && (state_q == ENTRY) &&
                    (cnt_q == CNT_W'(DIGITS)) && (disp_q == PASSWORD);
    act_fail      = press && key_dec.enter && (state_q == ENTRY) &&
                    (cnt_q == CNT_W'(DIGITS)) && (disp_q != PASSWORD);
    act_clr_entry = press && key_dec.clr_entry && (state_q == ENTRY);
    act_relock    = press && key_dec.clr_entry && (state_q == OPEN);
    act_clr_all   = press && key_dec.clr_all;
    lock_done     = (LOCKOUT_CYC > 0) && (state_q == LOCKOUT) &&
                    (lock_cnt_q == LOCK_W'(LOCK_LAST));
    beep_start    = act_digit || act_ok || act_fail || act_clr_entry || act_clr_all;
    beep_kind     = act_fail ? BEEP_FAIL : (act_ok ? BEEP_OK : BEEP_KEY);
    key_accept    = beep_start || act_relock;

    disp_shift_d      = disp_q << 4;
    disp_shift_d[3:0] = key_dec.digit;
    tries_inc_d       = (tries_q == TRIES_W'(MAX_TRIES)) ? tries_q : tries_q + TRIES_W'(1);
  end

  // Lock FSM with registered display, try counter, status flags and key pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ENTRY;
      disp_q       <= ALL_BLANK;
      cnt_q        <= '0;
      tries_q      <= '0;
      lock_cnt_q   <= '0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
      key_evt_q    <= 1'b0;
      onehot_q     <= '0;
    end else begin
      onehot_q  <= onehot;
      key_evt_q <= key_accept;
      if (act_clr_all || lock_done) begin
        state_q      <= ENTRY;
        disp_q       <= ALL_BLANK;
        cnt_q        <= '0;
        tries_q      <= '0;
        lock_cnt_q   <= '0;
        unlocked_q   <= 1'b0;
        locked_out_q <= 1'b0;
      end else begin
        case (state_q)
          ENTRY: begin
            if (act_digit) begin
              disp_q <= disp_shift_d;
              cnt_q  <= cnt_q + CNT_W'(1);
            end else if (act_ok) begin
              state_q    <= OPEN;
              disp_q     <= ALL_OPEN;
              tries_q    <= '0;
              unlocked_q <= 1'b1;
            end else if (act_fail) begin
              tries_q <= tries_inc_d;
              disp_q  <= ALL_BLANK;
              cnt_q   <= '0;
              if (tries_inc_d == TRIES_W'(MAX_TRIES)) begin
                state_q      <= LOCKOUT;
                disp_q       <= ALL_LOCK;
                lock_cnt_q   <= '0;
                locked_out_q <= 1'b1;
              end
            end else if (act_clr_entry) begin
              disp_q <= ALL_BLANK;
              cnt_q  <= '0;
            end
          end
          OPEN: begin
            if (act_relock) begin
              state_q    <= ENTRY;
              disp_q     <= ALL_BLANK;
              cnt_q      <= '0;
              unlocked_q <= 1'b0;
            end
          end
          LOCKOUT: begin
            if (LOCKOUT_CYC > 0) begin
              lock_cnt_q <= lock_cnt_q + LOCK_W'(1);
            end
          end
          default: begin
            state_q <= ENTRY;
          end
        endcase
      end
    end
  end

  beep_gen #(
    .TONE_HALF    (TONE_HALF),
    .KEY_BEEP_CYC (KEY_BEEP_CYC),
    .OK_BEEP_CYC  (OK_BEEP_CYC),
    .FAIL_BEEP_CYC(FAIL_BEEP_CYC)
  ) u_beep (
    .clk   (clk),
    .rst   (rst),
    .start (beep_start),
    .kind  (beep_kind),
    .buzzer(buzzer)
  );

  assign disp       = disp_q;
  assign tries      = tries_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign key_evt    = key_evt_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Bench for keypad_lock_ctrl: two instances (untimed lockout with code
// 246, timed 20-cycle lockout with code 111) share one keypad input and
// are compared every cycle against a behavioural model of the lock rules.
module tb_keypad_lock_ctrl;

  localparam int TH       = 3;
  localparam int KEY_LEN  = 5;
  localparam int OK_LEN   = 11;
  localparam int FAIL_LEN = 17;
  localparam int MAXT     = 6;
  localparam int ND       = 3;
  localparam int K_ENTER  = 10;
  localparam int K_CE     = 11;
  localparam int K_CA     = 12;
  localparam int M_ENTRY  = 0;
  localparam int M_OPEN   = 1;
  localparam int M_LOCK   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] onehot = 16'h0;
  logic [11:0] disp_w  [2];
  logic [2:0]  tries_w [2];
  logic        unl_w   [2];
  logic        lko_w   [2];
  logic        evt_w   [2];
  logic        buz_w   [2];

  always #5 clk = ~clk;

  keypad_lock_ctrl #(
    .DIGITS(ND), .PASSWORD(12'h246), .MAX_TRIES(MAXT), .LOCKOUT_CYC(0),
    .TONE_HALF(TH), .KEY_BEEP_CYC(KEY_LEN), .OK_BEEP_CYC(OK_LEN), .FAIL_BEEP_CYC(FAIL_LEN)
  ) dut_a (
    .clk(clk), .rst(rst), .onehot(onehot), .disp(disp_w[0]), .tries(tries_w[0]),
    .unlocked(unl_w[0]), .locked_out(lko_w[0]), .key_evt(evt_w[0]), .buzzer(buz_w[0])
  );

  keypad_lock_ctrl #(
    .DIGITS(ND), .PASSWORD(12'h111), .MAX_TRIES(MAXT), .LOCKOUT_CYC(20),
    .TONE_HALF(TH), .KEY_BEEP_CYC(KEY_LEN), .OK_BEEP_CYC(OK_LEN), .FAIL_BEEP_CYC(FAIL_LEN)
  ) dut_b (
    .clk(clk), .rst(rst), .onehot(onehot), .disp(disp_w[1]), .tries(tries_w[1]),
    .unlocked(unl_w[1]), .locked_out(lko_w[1]), .key_evt(evt_w[1]), .buzzer(buz_w[1])
  );

  // Keypad bit -> key: digits 0..9, 10 ENTER, 11 CLEAR_ENTRY, 12 CLEAR_ALL, -1 none
  int keymap [16] = '{K_ENTER, -1, -1, 0, -1, 3, 2, 1, K_CA, 6, 5, 4, K_CE, 9, 8, 7};
  int pw     [2]  = '{32'h246, 32'h111};
  int lcyc   [2]  = '{0, 20};
  string nm  [2]  = '{"A", "B"};

  int          mst      [2];
  int          ent      [2][ND];
  int          ecnt     [2];
  int          mtries   [2];
  int          lock_t0  [2];
  int          beep_t0  [2];
  int          beep_len [2];
  bit          mevt     [2];
  logic [15:0] prev_oh = 16'h0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int decode(input logic [15:0] oh);
    if ($countones(oh) != 1) return -1;
    for (int b = 0; b < 16; b++) if (oh[b]) return keymap[b];
    return -1;
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    for (int b = 0; b < 16; b++) if (keymap[b] == k) return 16'(1) << b;
    return 16'h0;
  endfunction

  task automatic start_beep(input int i, input int len);
    beep_t0[i]  = cyc;
    beep_len[i] = len;
  endtask

  task automatic model_step(input int i);
    int  k;
    bit  ev;
    int  val;
    mevt[i] = 1'b0;
    if (rst) begin
      mst[i] = M_ENTRY; ecnt[i] = 0; mtries[i] = 0; beep_len[i] = 0;
      return;
    end
    k  = decode(onehot);
    ev = (prev_oh == 16'h0) && (k >= 0);
    if (ev && k == K_CA) begin
      mst[i] = M_ENTRY; ecnt[i] = 0; mtries[i] = 0; mevt[i] = 1'b1;
      start_beep(i, KEY_LEN);
    end else if (mst[i] == M_LOCK && lcyc[i] > 0 && (cyc - lock_t0[i]) == lcyc[i]) begin
      mst[i] = M_ENTRY; ecnt[i] = 0; mtries[i] = 0;
    end else if (ev) begin
      if (mst[i] == M_ENTRY) begin
        if (k <= 9) begin
          if (ecnt[i] < ND) begin
            ent[i][ecnt[i]] = k; ecnt[i]++; mevt[i] = 1'b1;
            start_beep(i, KEY_LEN);
          end
        end else if (k == K_ENTER) begin
          if (ecnt[i] == ND) begin
            val = 0;
            for (int j = 0; j < ND; j++) val = val * 16 + ent[i][j];
            mevt[i] = 1'b1;
            if (val == pw[i]) begin
              mst[i] = M_OPEN; mtries[i] = 0;
              start_beep(i, OK_LEN);
            end else begin
              mtries[i]++; ecnt[i] = 0;
              start_beep(i, FAIL_LEN);
              if (mtries[i] == MAXT) begin
                mst[i] = M_LOCK; lock_t0[i] = cyc;
              end
            end
          end
        end else if (k == K_CE) begin
          ecnt[i] = 0; mevt[i] = 1'b1;
          start_beep(i, KEY_LEN);
        end
      end else if (mst[i] == M_OPEN && k == K_CE) begin
        mst[i] = M_ENTRY; ecnt[i] = 0; mevt[i] = 1'b1;
      end
    end
  endtask

  function automatic logic [11:0] exp_disp(input int i);
    logic [11:0] d;
    if (mst[i] == M_OPEN) return 12'hCCC;
    if (mst[i] == M_LOCK) return 12'h000;
    d = 12'hFFF;
    for (int j = 0; j < ecnt[i]; j++) d[4*(ecnt[i]-1-j) +: 4] = 4'(ent[i][j]);
    return d;
  endfunction

  function automatic logic exp_buz(input int i);
    int k;
    if (beep_len[i] == 0) return 1'b0;
    k = cyc - beep_t0[i];
    if (k >= beep_len[i]) return 1'b0;
    return ((k / TH) % 2) == 0;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.disp", nm[i]),       32'(disp_w[i]),  32'(exp_disp(i)));
      chk($sformatf("%s.tries", nm[i]),      32'(tries_w[i]), 32'(mtries[i]));
      chk($sformatf("%s.unlocked", nm[i]),   32'(unl_w[i]),   32'(mst[i] == M_OPEN));
      chk($sformatf("%s.locked_out", nm[i]), 32'(lko_w[i]),   32'(mst[i] == M_LOCK));
      chk($sformatf("%s.key_evt", nm[i]),    32'(evt_w[i]),   32'(mevt[i]));
      chk($sformatf("%s.buzzer", nm[i]),     32'(buz_w[i]),   32'(exp_buz(i)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step(0);
    model_step(1);
    prev_oh = rst ? 16'h0 : onehot;
    #1;
    check_all();
  endtask

  task automatic press(input int k);
    onehot = mask_of(k);
    tick();
    onehot = 16'h0;
    tick();
    tick();
  endtask

  initial begin
    int na;
    int nb;
    int r;
    int kpool [16] = '{1, 2, 4, 6, 1, 2, 4, 6, K_ENTER, K_ENTER, K_ENTER, K_CE, K_CA, 0, 9, 7};

    rst = 1'b1; onehot = 16'h0;
    repeat (3) tick();
    chk("reset.disp", 32'(disp_w[0]), 32'h0FFF);
    chk("reset.buzzer", 32'(buz_w[0]), 32'h0);
    rst = 1'b0;
    tick();

    // Correct code opens lock A; B sees a wrong code
    press(2); press(4); press(6);
    chk("A.entry246", 32'(disp_w[0]), 32'h0246);
    press(K_ENTER);
    chk("A.open", 32'(unl_w[0]), 32'h1);
    chk("A.open_disp", 32'(disp_w[0]), 32'h0CCC);
    chk("B.try1", 32'(tries_w[1]), 32'h1);
    repeat (12) tick();

    // Repeated identical digits open B
    press(K_CA);
    press(1); press(1); press(1); press(K_ENTER);
    chk("B.open111", 32'(unl_w[1]), 32'h1);
    chk("A.try1", 32'(tries_w[0]), 32'h1);

    // A held key gives exactly one event
    press(K_CA);
    na = 0; nb = 0;
    onehot = mask_of(1);
    for (int c = 0; c < 100; c++) begin
      tick();
      if (evt_w[0]) na++;
      if (evt_w[1]) nb++;
    end
    onehot = 16'h0;
    tick(); tick();
    chk("A.hold_evts", 32'(na), 32'd1);
    chk("B.hold_evts", 32'(nb), 32'd1);
    chk("A.hold_disp", 32'(disp_w[0]), 32'h0FF1);

    // Six wrong codes lock both; B times out, A waits for CLEAR_ALL
    press(K_CA);
    for (int t = 1; t <= MAXT; t++) begin
      press(1); press(2); press(3); press(K_ENTER);
      chk($sformatf("A.tries%0d", t), 32'(tries_w[0]), 32'(t));
    end
    chk("A.locked", 32'(lko_w[0]), 32'h1);
    chk("A.lock_disp", 32'(disp_w[0]), 32'h0000);
    chk("B.locked", 32'(lko_w[1]), 32'h1);
    press(5);
    repeat (25) tick();
    chk("B.timeout", 32'(lko_w[1]), 32'h0);
    chk("B.timeout_tries", 32'(tries_w[1]), 32'h0);
    chk("B.timeout_disp", 32'(disp_w[1]), 32'h0FFF);
    chk("A.still_locked", 32'(lko_w[0]), 32'h1);
    chk("A.lock_tries", 32'(tries_w[0]), 32'd6);
    press(K_CA);
    chk("A.clear_all", 32'(lko_w[0]), 32'h0);
    chk("A.clear_tries", 32'(tries_w[0]), 32'h0);

    // Short ENTER, overflow digit, CLEAR_ENTRY
    press(2); press(4); press(K_ENTER);
    chk("A.short_enter", 32'(disp_w[0]), 32'h0F24);
    chk("A.short_tries", 32'(tries_w[0]), 32'h0);
    press(6); press(7);
    chk("A.overflow", 32'(disp_w[0]), 32'h0246);
    press(K_CE);
    chk("A.clr_entry", 32'(disp_w[0]), 32'h0FFF);

    // Reset mid-FAIL-beep, then mid-entry
    press(1); press(2); press(3);
    onehot = mask_of(K_ENTER);
    tick();
    onehot = 16'h0;
    tick();
    chk("A.fail_beep_on", 32'(buz_w[0]), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("A.rst_buzzer", 32'(buz_w[0]), 32'h0);
    chk("A.rst_tries", 32'(tries_w[0]), 32'h0);
    press(5); press(6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("A.rst_disp", 32'(disp_w[0]), 32'h0FFF);
    tick();

    // Unused and multi-bit codes are not keys
    na = 0;
    onehot = 16'h0003;
    repeat (3) begin tick(); if (evt_w[0]) na++; end
    onehot = 16'h0;
    tick(); if (evt_w[0]) na++;
    onehot = 16'h0002;
    repeat (3) begin tick(); if (evt_w[0]) na++; end
    onehot = 16'h0;
    tick(); if (evt_w[0]) na++;
    chk("A.nokey_evts", 32'(na), 32'd0);
    chk("A.nokey_disp", 32'(disp_w[0]), 32'h0FFF);

    // Random keypad traffic
    for (int it = 0; it < 700; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1; onehot = 16'h0;
        tick();
        rst = 1'b0;
      end else if (r < 60) begin
        onehot = mask_of(kpool[$urandom_range(0, 15)]);
        repeat ($urandom_range(1, 3)) tick();
        onehot = 16'h0;
        repeat ($urandom_range(0, 2)) tick();
      end else if (r < 75) begin
        onehot = 16'($urandom_range(0, 65535));
        repeat ($urandom_range(1, 2)) tick();
      end else begin
        onehot = 16'h0;
        repeat ($urandom_range(1, 5)) tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
